mem_access_ctrl: RTL

//   Sequences the data-memory access for the instruction held in the EX/MEM register
//   of the 5-stage pipeline.

---
 rtl/mem_ctrl_pkg.sv | 8 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the M-stage data-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating BUSY-cycle counter; expired flags the last allowed wait cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    // Holds at LAST so a long BUSY never wraps back into a fresh window.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the EX/MEM instruction's data-memory access over a req/ack port,
// stalling the pipeline until completion and capturing load data.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned word_width     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [word_width-1:0] mem_addr,
    output logic [word_width-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [word_width-1:0] mem_rdata,
    output logic                  StallM,
    output logic [word_width-1:0] ReadDataM,
    output logic                  MisalignM,
    output logic                  BusErrM
);

    mem_state_t state_q, state_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [word_width-1:0] mem_addr_q, mem_addr_d;
    logic [word_width-1:0] mem_wdata_q, mem_wdata_d;
    logic [word_width-1:0] read_data_q, read_data_d;

    logic access, misaligned, launch, expired;
    logic stall, misalign, bus_err;

    // RegWriteM is carried for load-use detection elsewhere and does not gate access.
    logic unused_regwrite;
    assign unused_regwrite = RegWriteM;

    assign access     = MemWriteM | (ResultSrcM == RESULTSRC_LOAD);
    assign misaligned = (ALUResultM[1:0] != 2'b00);
    assign launch     = (state_q == IDLE) && access && !misaligned;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (launch),
        .en     (state_q == BUSY),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        read_data_d = read_data_q;
        stall       = 1'b0;
        misalign    = 1'b0;
        bus_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWriteM;
                        mem_addr_d  = ALUResultM;
                        mem_wdata_d = WriteDataM;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A late ack on the final window cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        read_data_d = mem_rdata;
                    end
                end else if (expired) begin
                    bus_err     = 1'b1;
                    mem_req_d   = 1'b0;
                    read_data_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Combinational flags are forced low while reset is held, even if M still presents an access.
    assign StallM    = stall & ~reset;
    assign MisalignM = misalign & ~reset;
    assign BusErrM   = bus_err & ~reset;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ReadDataM = read_data_q;

endmodule
